// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute controller for the 9-bit accumulator datapath.
// Define SEQ_STEP_EN to add the single-step input (step) and the PAUSE state.
module cpu_sequencer #(
    parameter int unsigned PC_W         = 9,
    parameter int unsigned PC_STEP      = 4,
    parameter bit          ILLEGAL_HALT = 1'b0
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            run,
`ifdef SEQ_STEP_EN
    input  logic            step,
`endif
    input  logic            instr_valid,
    input  logic [8:0]      instr_data,
    output logic            instr_ready,
    output logic [PC_W-1:0] pc,
    output logic [2:0]      alu_op,
    output logic            is_add,
    output logic            is_imm,
    output logic            reg_we,
    output logic            sram_cs,
    output logic            sram_rd,
    output logic            sram_we,
    output logic            busy,
    output logic            halted,
    output logic            illegal
);

    localparam int unsigned OPC_W = 4;
    localparam int unsigned ALU_W = 3;

    localparam logic [OPC_W-1:0] OP_MOVI  = 4'd0;
    localparam logic [OPC_W-1:0] OP_MOV   = 4'd1;
    localparam logic [OPC_W-1:0] OP_ADD   = 4'd2;
    localparam logic [OPC_W-1:0] OP_SUB   = 4'd3;
    localparam logic [OPC_W-1:0] OP_AND   = 4'd4;
    localparam logic [OPC_W-1:0] OP_OR    = 4'd5;
    localparam logic [OPC_W-1:0] OP_STORE = 4'd6;
    localparam logic [OPC_W-1:0] OP_LOAD  = 4'd7;
    localparam logic [OPC_W-1:0] OP_HALT  = 4'd8;

    localparam logic [ALU_W-1:0] ALU_FWD = 3'b000;
    localparam logic [ALU_W-1:0] ALU_ADD = 3'b001;
    localparam logic [ALU_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b011;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC     = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WAIT = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB       = 4'd7,
        S_HALTED   = 4'd8
`ifdef SEQ_STEP_EN
        ,
        S_PAUSE    = 4'd9
`endif
    } state_t;

    // Where a completed instruction goes when the sequencer keeps running.
`ifdef SEQ_STEP_EN
    localparam state_t S_RESUME = S_PAUSE;
`else
    localparam state_t S_RESUME = S_FETCH;
`endif

    state_t           state;
    state_t           state_d;
    logic [OPC_W-1:0] opc_q;
    logic             accept;
    logic             opc_alu;
    logic             opc_illegal;

    logic [PC_W-1:0]  pc_d;
    logic [ALU_W-1:0] alu_op_d;
    logic             is_add_d;
    logic             is_imm_d;
    logic             reg_we_d;
    logic             sram_cs_d;
    logic             sram_rd_d;
    logic             sram_we_d;
    logic             busy_d;
    logic             halted_d;
    logic             illegal_d;

    // Operand and spare bits of the word belong to the datapath, not the sequencer.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr_data[8:5], instr_data[0]};

    assign instr_ready = (state == S_FETCH);
    assign accept      = instr_ready && instr_valid;
    assign opc_alu     = (opc_q < OP_STORE);
    assign opc_illegal = (opc_q > OP_HALT);

    // State and registered outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= S_IDLE;
            opc_q   <= '0;
            pc      <= '0;
            alu_op  <= ALU_FWD;
            is_add  <= 1'b1;
            is_imm  <= 1'b0;
            reg_we  <= 1'b0;
            sram_cs <= 1'b0;
            sram_rd <= 1'b0;
            sram_we <= 1'b0;
            busy    <= 1'b0;
            halted  <= 1'b0;
            illegal <= 1'b0;
        end else begin
            state   <= state_d;
            if (accept) begin
                opc_q <= instr_data[4:1];
            end
            pc      <= pc_d;
            alu_op  <= alu_op_d;
            is_add  <= is_add_d;
            is_imm  <= is_imm_d;
            reg_we  <= reg_we_d;
            sram_cs <= sram_cs_d;
            sram_rd <= sram_rd_d;
            sram_we <= sram_we_d;
            busy    <= busy_d;
            halted  <= halted_d;
            illegal <= illegal_d;
        end
    end

    // Next-state logic; run is only looked at in IDLE, FETCH and WB.
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (accept) begin
                    state_d = S_DECODE;
                end else if (!run) begin
                    state_d = S_IDLE;
                end
            end
            S_DECODE: begin
                if (opc_alu) begin
                    state_d = S_EXEC;
                end else if (opc_q == OP_STORE) begin
                    state_d = S_MEM_WR;
                end else if (opc_q == OP_LOAD) begin
                    state_d = S_MEM_RD;
                end else if (opc_q == OP_HALT) begin
                    state_d = S_HALTED;
                end else begin
                    state_d = ILLEGAL_HALT ? S_HALTED : S_FETCH;
                end
            end
            S_EXEC:     state_d = S_WB;
            S_MEM_RD:   state_d = S_MEM_WAIT;
            S_MEM_WAIT: state_d = S_WB;
            S_MEM_WR:   state_d = S_RESUME;
            S_WB:       state_d = run ? S_RESUME : S_IDLE;
            S_HALTED:   state_d = S_HALTED;
`ifdef SEQ_STEP_EN
            S_PAUSE: begin
                if (step) begin
                    state_d = S_FETCH;
                end
            end
`endif
            default:    state_d = S_IDLE;
        endcase
    end

    // Output logic: strobes follow the state being entered so they are registered yet state-aligned.
    always_comb begin
        pc_d      = pc;
        alu_op_d  = alu_op;
        is_add_d  = is_add;
        is_imm_d  = is_imm;
        illegal_d = illegal;

        if (accept) begin
            pc_d = pc + PC_W'(PC_STEP);
        end

        if (state == S_DECODE) begin
            case (opc_q)
                OP_MOVI: begin
                    alu_op_d = ALU_FWD;
                    is_add_d = 1'b1;
                    is_imm_d = 1'b1;
                end
                OP_MOV: begin
                    alu_op_d = ALU_FWD;
                    is_add_d = 1'b1;
                    is_imm_d = 1'b0;
                end
                OP_ADD: begin
                    alu_op_d = ALU_ADD;
                    is_add_d = 1'b1;
                    is_imm_d = 1'b0;
                end
                OP_SUB: begin
                    alu_op_d = ALU_ADD;
                    is_add_d = 1'b0;
                    is_imm_d = 1'b0;
                end
                OP_AND: begin
                    alu_op_d = ALU_AND;
                    is_add_d = 1'b1;
                    is_imm_d = 1'b0;
                end
                OP_OR: begin
                    alu_op_d = ALU_OR;
                    is_add_d = 1'b1;
                    is_imm_d = 1'b0;
                end
                default: begin
                end
            endcase
            if (opc_illegal) begin
                illegal_d = 1'b1;
            end
        end

        reg_we_d  = (state_d == S_WB);
        sram_rd_d = (state_d == S_MEM_RD);
        sram_we_d = (state_d == S_MEM_WR);
        sram_cs_d = sram_rd_d || sram_we_d;
        busy_d    = !(state_d inside {S_IDLE, S_HALTED});
        halted_d  = (state_d == S_HALTED);
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: strobe events are predicted at accept time and
// matched (cycle and ALU controls) by a negedge monitor.
module tb_cpu_sequencer;

    localparam int unsigned PC_W = 9;
    localparam int K_WB = 0;
    localparam int K_WR = 1;
    localparam int K_RD = 2;

    typedef struct {
        int         kind;
        int         cyc;
        logic [2:0] op;
        logic       add;
        logic       imm;
        bit         chk_imm;
    } exp_t;

    logic            CLK = 1'b0;
    logic            RESET;
    logic            run;
    logic            instr_valid;
    logic [8:0]      instr_data;
    logic            instr_ready;
    logic [PC_W-1:0] pc;
    logic [2:0]      alu_op;
    logic            is_add;
    logic            is_imm;
    logic            reg_we;
    logic            sram_cs;
    logic            sram_rd;
    logic            sram_we;
    logic            busy;
    logic            halted;
    logic            illegal;
`ifdef SEQ_STEP_EN
    logic            step = 1'b1;
`endif

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    exp_t exp_q[$];

    logic [PC_W-1:0] pc_model;
    logic [2:0]      m_op;
    logic            m_add;
    logic            m_imm;
    bit              m_chk_imm;

    cpu_sequencer dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .run         (run),
`ifdef SEQ_STEP_EN
        .step        (step),
`endif
        .instr_valid (instr_valid),
        .instr_data  (instr_data),
        .instr_ready (instr_ready),
        .pc          (pc),
        .alu_op      (alu_op),
        .is_add      (is_add),
        .is_imm      (is_imm),
        .reg_we      (reg_we),
        .sram_cs     (sram_cs),
        .sram_rd     (sram_rd),
        .sram_we     (sram_we),
        .busy        (busy),
        .halted      (halted),
        .illegal     (illegal)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation still running at %0t, required to finish", $time);
        $fatal(1, "timeout");
    end

    // Monitor: strobe exclusivity every cycle, and every strobe cycle must match the scoreboard head.
    logic  mon_s;
    string mon_nm;
    exp_t  mon_e;
    always @(negedge CLK) begin
        if (RESET === 1'b0) begin
            vectors++;
            if ((sram_rd && sram_we) || (sram_cs !== (sram_rd | sram_we))) begin
                miscompares++;
                $display("FAIL strobe_excl: cs=%b rd=%b we=%b at cycle %0d, required cs=rd|we and not rd&we",
                         sram_cs, sram_rd, sram_we, cyc);
            end
            for (int k = 0; k < 3; k++) begin
                mon_s  = (k == K_WB) ? reg_we : ((k == K_WR) ? sram_we : sram_rd);
                mon_nm = (k == K_WB) ? "reg_we" : ((k == K_WR) ? "sram_we" : "sram_rd");
                if (mon_s !== 1'b0) begin
                    vectors++;
                    if (exp_q.size() == 0 || exp_q[0].kind != k) begin
                        miscompares++;
                        $display("FAIL unexpected_%s: strobe=%b at cycle %0d, required no strobe", mon_nm, mon_s, cyc);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (mon_e.cyc != cyc || mon_s !== 1'b1 ||
                            (k == K_WB && (alu_op !== mon_e.op || is_add !== mon_e.add ||
                                           (mon_e.chk_imm && is_imm !== mon_e.imm)))) begin
                            miscompares++;
                            $display("FAIL event_%s: cycle %0d alu_op=%b is_add=%b is_imm=%b, required cycle %0d alu_op=%b is_add=%b is_imm=%b",
                                     mon_nm, cyc, alu_op, is_add, is_imm, mon_e.cyc, mon_e.op, mon_e.add, mon_e.imm);
                        end
                    end
                end
            end
        end
    end

    function automatic logic [8:0] enc(input logic [3:0] op);
        return {4'($urandom), op, 1'($urandom)};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        pc_model  = '0;
        m_op      = 3'b000;
        m_add     = 1'b1;
        m_imm     = 1'b0;
        m_chk_imm = 1'b1;
    endtask

    // Present a word, wait (bounded) for the handshake, predict its strobe events.
    task automatic issue(input logic [8:0] word);
        int         n = 0;
        int         c;
        logic [3:0] op;
        op          = word[4:1];
        instr_data  = word;
        instr_valid = 1'b1;
        while (instr_ready !== 1'b1 && n < 20) begin
            @(posedge CLK); #1;
            n++;
        end
        vectors++;
        if (instr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_timeout: instr_ready=%b after %0d cycles, required 1", instr_ready, n);
            instr_valid = 1'b0;
            return;
        end
        c = cyc;
        case (op)
            4'd0: begin m_op = 3'b000; m_add = 1'b1; m_imm = 1'b1; m_chk_imm = 1'b1; end
            4'd1: begin m_op = 3'b000; m_add = 1'b1; m_imm = 1'b0; m_chk_imm = 1'b1; end
            4'd2: begin m_op = 3'b001; m_add = 1'b1; m_chk_imm = 1'b0; end
            4'd3: begin m_op = 3'b001; m_add = 1'b0; m_chk_imm = 1'b0; end
            4'd4: begin m_op = 3'b010; m_add = 1'b1; m_chk_imm = 1'b0; end
            4'd5: begin m_op = 3'b011; m_add = 1'b1; m_chk_imm = 1'b0; end
            default: begin end
        endcase
        if (op < 4'd6) begin
            exp_q.push_back('{K_WB, c + 3, m_op, m_add, m_imm, m_chk_imm});
        end else if (op == 4'd6) begin
            exp_q.push_back('{K_WR, c + 2, 3'b000, 1'b0, 1'b0, 1'b0});
        end else if (op == 4'd7) begin
            exp_q.push_back('{K_RD, c + 2, 3'b000, 1'b0, 1'b0, 1'b0});
            exp_q.push_back('{K_WB, c + 4, m_op, m_add, m_imm, m_chk_imm});
        end
        @(posedge CLK); #1;
        instr_valid = 1'b0;
        pc_model    = pc_model + PC_W'(4);
        vectors++;
        if (pc !== pc_model) begin
            miscompares++;
            $display("FAIL pc_after_accept: pc=%0d, required %0d", pc, pc_model);
        end
    endtask

    // Wait (bounded) until every predicted event has been seen and FETCH is back.
    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || instr_ready !== 1'b1) && n < 40) begin
            @(posedge CLK); #1;
            n++;
        end
        vectors++;
        if (exp_q.size() != 0 || instr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL drain: %0d events pending, instr_ready=%b, required 0 pending and ready=1",
                     exp_q.size(), instr_ready);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1; run = 1'b0; instr_valid = 1'b0; instr_data = '0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        vectors++;
        if ({instr_ready, pc, alu_op, is_add, is_imm, reg_we, sram_cs, sram_rd, sram_we, busy, halted, illegal}
            !== {1'b0, 9'd0, 3'b000, 1'b1, 1'b0, 7'b0}) begin
            miscompares++;
            $display("FAIL reset_values: ready=%b pc=%0d alu_op=%b add=%b imm=%b we=%b cs=%b rd=%b swe=%b busy=%b halted=%b ill=%b, required pc=0 add=1 rest 0",
                     instr_ready, pc, alu_op, is_add, is_imm, reg_we, sram_cs, sram_rd, sram_we, busy, halted, illegal);
        end
        RESET = 1'b0;
        repeat (3) begin
            @(posedge CLK); #1;
            vectors++;
            if (instr_ready !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_hold: instr_ready=%b busy=%b with run=0, required 0 0", instr_ready, busy);
            end
        end
    endtask

    task automatic test_add();
        run = 1'b1;
        @(posedge CLK); #1;
        vectors++;
        if (instr_ready !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL fetch_entry: instr_ready=%b busy=%b, required 1 1", instr_ready, busy);
        end
        issue(9'b0_0000_0100);
        @(posedge CLK); #1;
        vectors++;
        if (alu_op !== 3'b001 || is_add !== 1'b1 || reg_we !== 1'b0) begin
            miscompares++;
            $display("FAIL add_exec: alu_op=%b is_add=%b reg_we=%b, required 001 1 0", alu_op, is_add, reg_we);
        end
        @(posedge CLK); #1;
        vectors++;
        if (reg_we !== 1'b1 || pc !== 9'd4) begin
            miscompares++;
            $display("FAIL add_wb: reg_we=%b pc=%0d at cycle 3, required 1 and 4", reg_we, pc);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        issue(enc(4'd6));
        issue(enc(4'd7));
        drain();
        issue(enc(4'd7));
        issue(enc(4'd6));
        drain();
    endtask

    task automatic test_sub_stall();
        logic [8:0] w;
        w           = enc(4'd3);
        instr_data  = w;
        instr_valid = 1'b0;
        repeat (5) begin
            @(posedge CLK); #1;
            vectors++;
            if (instr_ready !== 1'b1 || pc !== pc_model) begin
                miscompares++;
                $display("FAIL stall_hold: instr_ready=%b pc=%0d, required 1 and %0d", instr_ready, pc, pc_model);
            end
        end
        issue(w);
        @(posedge CLK); #1;
        vectors++;
        if (alu_op !== 3'b001 || is_add !== 1'b0) begin
            miscompares++;
            $display("FAIL sub_controls: alu_op=%b is_add=%b, required 001 0", alu_op, is_add);
        end
        drain();
    endtask

    task automatic test_illegal();
        issue(enc(4'd12));
        @(posedge CLK); #1;
        vectors++;
        if (illegal !== 1'b1 || instr_ready !== 1'b1 || halted !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_op: illegal=%b instr_ready=%b halted=%b, required 1 1 0", illegal, instr_ready, halted);
        end
        issue(enc(4'd1));
        drain();
        vectors++;
        if (illegal !== 1'b1) begin
            miscompares++;
            $display("FAIL illegal_sticky: illegal=%b, required 1", illegal);
        end
    endtask

    task automatic test_pc_wrap();
        RESET = 1'b1;
        @(posedge CLK); #1;
        model_reset();
        vectors++;
        if (pc !== 9'd0 || illegal !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_reset: pc=%0d illegal=%b, required 0 0", pc, illegal);
        end
        RESET = 1'b0;
        for (int i = 0; i < 128; i++) begin
            issue(enc(4'($urandom_range(0, 5))));
            if (i == 126) begin
                vectors++;
                if (pc !== 9'd508) begin
                    miscompares++;
                    $display("FAIL pc_pre_wrap: pc=%0d, required 508", pc);
                end
            end
        end
        vectors++;
        if (pc !== 9'd0) begin
            miscompares++;
            $display("FAIL pc_wrap: pc=%0d, required 0", pc);
        end
        drain();
    endtask

    task automatic test_reset_mid_load();
        issue(enc(4'd7));
        @(posedge CLK); #1;
        vectors++;
        if (sram_rd !== 1'b1 || sram_cs !== 1'b1) begin
            miscompares++;
            $display("FAIL load_rd: sram_rd=%b sram_cs=%b, required 1 1", sram_rd, sram_cs);
        end
        @(posedge CLK); #1;
        RESET = 1'b1;
        run   = 1'b0;
        #1;
        model_reset();
        vectors++;
        if ({reg_we, sram_cs, sram_rd, sram_we, busy, instr_ready} !== 6'b0 || pc !== 9'd0) begin
            miscompares++;
            $display("FAIL reset_mid_load: we=%b cs=%b rd=%b swe=%b busy=%b ready=%b pc=%0d, required all 0",
                     reg_we, sram_cs, sram_rd, sram_we, busy, instr_ready, pc);
        end
        @(posedge CLK); #1;
        RESET = 1'b0;
        repeat (5) begin
            @(posedge CLK); #1;
            vectors++;
            if (instr_ready !== 1'b0 || reg_we !== 1'b0) begin
                miscompares++;
                $display("FAIL post_reset_idle: instr_ready=%b reg_we=%b, required 0 0", instr_ready, reg_we);
            end
        end
        run = 1'b1;
        issue(enc(4'd5));
        drain();
    endtask

    task automatic test_halt();
        issue(enc(4'd8));
        instr_data  = enc(4'd2);
        instr_valid = 1'b1;
        repeat (10) begin
            @(posedge CLK); #1;
            vectors++;
            if (halted !== 1'b1 || instr_ready !== 1'b0 || busy !== 1'b0 || pc !== pc_model) begin
                miscompares++;
                $display("FAIL halt_state: halted=%b ready=%b busy=%b pc=%0d, required 1 0 0 %0d",
                         halted, instr_ready, busy, pc, pc_model);
            end
        end
        instr_valid = 1'b0;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL halt_pending: %0d events pending, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_sub_stall();
        test_illegal();
        test_pc_wrap();
        test_reset_mid_load();
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
